// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler: lamp codes, phase codes
// and the street selector used to alternate greens around a pedestrian phase.
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_RED    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        AG  = 3'd0,
        AY  = 3'd1,
        BG  = 3'd2,
        BY  = 3'd3,
        PED = 3'd4
    } phase_t;

    typedef enum logic {
        STREET_A = 1'b0,
        STREET_B = 1'b1
    } street_t;

    function automatic light_t light_a(input phase_t p);
        case (p)
            AG:      return LIGHT_GREEN;
            AY:      return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

    function automatic light_t light_b(input phase_t p);
        case (p)
            BG:      return LIGHT_GREEN;
            BY:      return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for per-phase timing; decrements on tick and saturates at 0.
// A load always takes priority over counting.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (load) begin
            count_reg <= load_val;
        end else if (tick && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == W'(1));

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-street intersection sequencer with a pedestrian all-red phase.
// Lamp outputs are registered decodes of the next phase, so they change with the phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 3,
    parameter int GREEN_MAX = 6,
    parameter int YELLOW_T  = 2,
    parameter int PED_T     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       Ta,
    input  logic       Tb,
    input  logic       ped_req,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic       walk,
    output logic [3:0] count,
    output logic [2:0] phase
);

    localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_MAX);
    localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_T);
    localparam logic [3:0] PED_LOAD    = 4'(PED_T);
    localparam logic [3:0] EARLY_LIMIT = 4'(GREEN_MAX - GREEN_MIN + 1);

    phase_t     state_reg, state_next;
    street_t    next_street_reg, next_street_next;
    logic       ped_pending_reg, ped_pending_next;
    light_t     la_reg, lb_reg;
    logic       walk_reg;
    logic       timer_load;
    logic [3:0] timer_load_val;
    logic [3:0] timer_count;
    logic       timer_last;

    phase_timer #(.W(4)) u_timer (
        .clk      (clk),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .count    (timer_count),
        .last     (timer_last)
    );

    always_comb begin
        state_next       = state_reg;
        next_street_next = next_street_reg;
        if (tick) begin
            case (state_reg)
                // An idle own street lets the other side in early once GREEN_MIN has elapsed.
                AG: if ((Tb || ped_pending_reg) &&
                        ((timer_count <= 4'd1) || (!Ta && (timer_count <= EARLY_LIMIT))))
                        state_next = AY;
                BG: if ((Ta || ped_pending_reg) &&
                        ((timer_count <= 4'd1) || (!Tb && (timer_count <= EARLY_LIMIT))))
                        state_next = BY;
                AY: if (timer_last) begin
                        state_next       = ped_pending_reg ? PED : BG;
                        next_street_next = STREET_B;
                    end
                BY: if (timer_last) begin
                        state_next       = ped_pending_reg ? PED : AG;
                        next_street_next = STREET_A;
                    end
                PED: if (timer_last)
                        state_next = (next_street_reg == STREET_A) ? AG : BG;
                default: state_next = AG;
            endcase
        end
    end

    always_comb begin
        ped_pending_next = ped_pending_reg;
        if (state_reg == PED) begin
            ped_pending_next = ped_pending_reg;
        end else if (state_next == PED) begin
            ped_pending_next = 1'b0;
        end else if (ped_req) begin
            ped_pending_next = 1'b1;
        end
    end

    always_comb begin
        timer_load = !reset_n || (state_next != state_reg);
        case (state_next)
            AY, BY:  timer_load_val = YELLOW_LOAD;
            PED:     timer_load_val = PED_LOAD;
            default: timer_load_val = GREEN_LOAD;
        endcase
        if (!reset_n) begin
            timer_load_val = GREEN_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= AG;
            next_street_reg <= STREET_B;
            ped_pending_reg <= 1'b0;
            la_reg          <= LIGHT_GREEN;
            lb_reg          <= LIGHT_RED;
            walk_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            next_street_reg <= next_street_next;
            ped_pending_reg <= ped_pending_next;
            la_reg          <= light_a(state_next);
            lb_reg          <= light_b(state_next);
            walk_reg        <= (state_next == PED);
        end
    end

    assign La    = la_reg;
    assign Lb    = lb_reg;
    assign walk  = walk_reg;
    assign count = timer_count;
    assign phase = state_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed, table-driven bench for traffic_phase_scheduler with default parameters.
// Each record gives the inputs for one clock edge and the outputs expected after it.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_AG  = 3'd0;
    localparam logic [2:0] P_AY  = 3'd1;
    localparam logic [2:0] P_BG  = 3'd2;
    localparam logic [2:0] P_BY  = 3'd3;
    localparam logic [2:0] P_PED = 3'd4;

    logic       clk = 1'b0;
    logic       reset_n, tick, Ta, Tb, ped_req;
    logic [1:0] La, Lb;
    logic       walk;
    logic [3:0] count;
    logic [2:0] phase;

    always #5 clk = ~clk;

    traffic_phase_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .Ta      (Ta),
        .Tb      (Tb),
        .ped_req (ped_req),
        .La      (La),
        .Lb      (Lb),
        .walk    (walk),
        .count   (count),
        .phase   (phase)
    );

    typedef struct {
        logic       rst_n;
        logic       tk;
        logic       ta;
        logic       tb_s;
        logic       pr;
        logic [2:0] ph;
        logic [3:0] cnt;
        logic       pp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic t, input logic ta, input logic tbs,
                       input logic p, input logic [2:0] ph, input int cnt, input logic pp);
        vec_t v;
        v.rst_n = r; v.tk = t; v.ta = ta; v.tb_s = tbs; v.pr = p;
        v.ph = ph; v.cnt = 4'(cnt); v.pp = pp;
        vecs.push_back(v);
    endtask

    // Three idle cycles holding the current phase, then one tick that moves to the next value.
    task automatic add_slow(input logic [2:0] ph0, input int c0, input logic [2:0] ph1, input int c1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1, 0, ph0, c0, 0);
        add(1, 1, 0, 1, 0, ph1, c1, 0);
    endtask

    function automatic logic [1:0] exp_la(input logic [2:0] ph);
        if (ph == P_AG) return 2'b00;
        if (ph == P_AY) return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] exp_lb(input logic [2:0] ph);
        if (ph == P_BG) return 2'b00;
        if (ph == P_BY) return 2'b01;
        return 2'b10;
    endfunction

    task automatic check(input int idx, input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %0d, expected %0d", idx, name, act, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; tick = 1'b1; Ta = 1'b0; Tb = 1'b0; ped_req = 1'b0;

        // Reset held two cycles
        add(0, 1, 0, 0, 0, P_AG, 6, 0);
        add(0, 1, 0, 0, 0, P_AG, 6, 0);
        // No demand: AG counts down and holds at 0
        for (int k = 1; k <= 8; k++) add(1, 1, 1, 0, 0, P_AG, (k < 6) ? 6 - k : 0, 0);

        // Contested green both ways
        add(0, 1, 1, 1, 0, P_AG, 6, 0);
        for (int c = 5; c >= 1; c--) add(1, 1, 1, 1, 0, P_AG, c, 0);
        add(1, 1, 1, 1, 0, P_AY, 2, 0);
        add(1, 1, 1, 1, 0, P_AY, 1, 0);
        add(1, 1, 1, 1, 0, P_BG, 6, 0);
        for (int c = 5; c >= 1; c--) add(1, 1, 1, 1, 0, P_BG, c, 0);
        add(1, 1, 1, 1, 0, P_BY, 2, 0);
        add(1, 1, 1, 1, 0, P_BY, 1, 0);
        add(1, 1, 1, 1, 0, P_AG, 6, 0);

        // Early change: idle street A, waiting street B
        add(0, 1, 0, 1, 0, P_AG, 6, 0);
        add(1, 1, 0, 1, 0, P_AG, 5, 0);
        add(1, 1, 0, 1, 0, P_AG, 4, 0);
        add(1, 1, 0, 1, 0, P_AY, 2, 0);
        add(1, 1, 0, 1, 0, P_AY, 1, 0);
        add(1, 1, 0, 1, 0, P_BG, 6, 0);
        add(1, 1, 0, 1, 0, P_BG, 5, 0);

        // Same early change with a tick every 4th cycle
        add(0, 1, 0, 1, 0, P_AG, 6, 0);
        add_slow(P_AG, 6, P_AG, 5);
        add_slow(P_AG, 5, P_AG, 4);
        add_slow(P_AG, 4, P_AY, 2);
        add_slow(P_AY, 2, P_AY, 1);
        add_slow(P_AY, 1, P_BG, 6);

        // Pedestrian pulse with no traffic; second press during PED is ignored
        add(0, 1, 0, 0, 0, P_AG, 6, 0);
        add(1, 1, 0, 0, 1, P_AG, 5, 1);
        add(1, 1, 0, 0, 0, P_AG, 4, 1);
        add(1, 1, 0, 0, 0, P_AY, 2, 1);
        add(1, 1, 0, 0, 0, P_AY, 1, 1);
        add(1, 1, 0, 0, 0, P_PED, 4, 0);
        add(1, 1, 0, 0, 1, P_PED, 3, 0);
        add(1, 1, 0, 0, 0, P_PED, 2, 0);
        add(1, 1, 0, 0, 0, P_PED, 1, 0);
        add(1, 1, 0, 0, 0, P_BG, 6, 0);
        add(1, 1, 0, 0, 0, P_BG, 5, 0);
        add(1, 1, 0, 0, 0, P_BG, 4, 0);
        add(1, 1, 0, 0, 0, P_BG, 3, 0);

        // Request on the yellow-exit tick is not served by that exit; then reset at BY count=1
        add(0, 1, 1, 1, 0, P_AG, 6, 0);
        for (int c = 5; c >= 1; c--) add(1, 1, 1, 1, 0, P_AG, c, 0);
        add(1, 1, 1, 1, 0, P_AY, 2, 0);
        add(1, 1, 1, 1, 0, P_AY, 1, 0);
        add(1, 1, 1, 1, 1, P_BG, 6, 1);
        for (int c = 5; c >= 1; c--) add(1, 1, 1, 1, 0, P_BG, c, 1);
        add(1, 1, 1, 1, 0, P_BY, 2, 1);
        add(1, 1, 1, 1, 0, P_BY, 1, 1);
        add(0, 1, 1, 1, 0, P_AG, 6, 0);
        add(1, 1, 0, 0, 0, P_AG, 5, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rst_n;
            tick    = vecs[i].tk;
            Ta      = vecs[i].ta;
            Tb      = vecs[i].tb_s;
            ped_req = vecs[i].pr;
            @(posedge clk);
            #1;
            check(i, "phase", {1'b0, phase}, {1'b0, vecs[i].ph});
            check(i, "La", {2'b0, La}, {2'b0, exp_la(vecs[i].ph)});
            check(i, "Lb", {2'b0, Lb}, {2'b0, exp_lb(vecs[i].ph)});
            check(i, "walk", {3'b0, walk}, {3'b0, (vecs[i].ph == P_PED)});
            check(i, "count", count, vecs[i].cnt);
            check(i, "ped_pending", {3'b0, dut.ped_pending_reg}, {3'b0, vecs[i].pp});
            $display("vec %0d: rst_n=%0b tick=%0b Ta=%0b Tb=%0b ped=%0b -> phase=%0d La=%b Lb=%b walk=%0b count=%0d",
                     i, reset_n, tick, Ta, Tb, ped_req, phase, La, Lb, walk, count);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
